// File: rtl/digilock_controller.sv
// Four-digit BCD keypad lock: entry, compare, open/re-program and lockout after three failures.
// Optional macro DIGILOCK_AUTO_RELOCK_EN: OPEN relocks after UNLOCK_CYCLES idle cycles.
module digilock_controller #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          LOCKOUT_CYCLES = 1000,
  parameter int          UNLOCK_CYCLES  = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       confirm,
  input  logic       setup,
  output logic       unlocked,
  output logic       locked_out,
  output logic       alarm,
  output logic [1:0] attempts,
  output logic [1:0] pos
);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_LOCKOUT} state_t;

  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

  state_t            state_r, state_nxt_s;
  logic [1:0]        pos_r, pos_nxt_s;
  logic [1:0]        attempts_r, attempts_nxt_s;
  logic [15:0]       code_r, code_nxt_s;
  logic [15:0]       entry_r, entry_nxt_s;
  logic [15:0]       stage_r, stage_nxt_s;
  logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_nxt_s;
  logic              unlocked_r, locked_out_r, alarm_r;
  logic              digit_ok_s;
  logic              relock_expired_s;

  // Digit 0 lives in the top nibble, digit 3 in the bottom nibble.
  function automatic logic [15:0] set_digit(input logic [15:0] word, input logic [1:0] idx,
                                            input logic [3:0] d);
    logic [15:0] w;
    w = word;
    case (idx)
      2'd0:    w[15:12] = d;
      2'd1:    w[11:8]  = d;
      2'd2:    w[7:4]   = d;
      default: w[3:0]   = d;
    endcase
    return w;
  endfunction

  assign digit_ok_s = digit_valid && (digit <= 4'd9);

`ifdef DIGILOCK_AUTO_RELOCK_EN
  localparam int RELOCK_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam logic [RELOCK_W-1:0] RELOCK_LAST = RELOCK_W'(UNLOCK_CYCLES - 1);
  logic [RELOCK_W-1:0] relock_cnt_r;

  // Idle timer for OPEN; a valid setup digit restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      relock_cnt_r <= '0;
    end else if ((state_r != S_OPEN) || (setup && digit_ok_s)) begin
      relock_cnt_r <= '0;
    end else begin
      relock_cnt_r <= relock_cnt_r + RELOCK_W'(1);
    end
  end

  assign relock_expired_s = (state_r == S_OPEN) && (relock_cnt_r == RELOCK_LAST) &&
                            !(setup && digit_ok_s);
`else
  assign relock_expired_s = 1'b0;
`endif

  // Next-state and datapath decode for the lock sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    pos_nxt_s      = pos_r;
    attempts_nxt_s = attempts_r;
    code_nxt_s     = code_r;
    entry_nxt_s    = entry_r;
    stage_nxt_s    = stage_r;
    lock_cnt_nxt_s = lock_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (digit_ok_s) begin
          entry_nxt_s = set_digit(16'h0000, 2'd0, digit);
          pos_nxt_s   = 2'd1;
          state_nxt_s = S_ENTRY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ENTRY: begin
        if (confirm) begin
          entry_nxt_s = 16'h0000;
          pos_nxt_s   = 2'd0;
          state_nxt_s = S_IDLE;
        end else if (digit_ok_s) begin
          entry_nxt_s = set_digit(entry_r, pos_r, digit);
          pos_nxt_s   = pos_r + 2'd1;
          state_nxt_s = (pos_r == 2'd3) ? S_CHECK : S_ENTRY;
        end else begin
          state_nxt_s = S_ENTRY;
        end
      end
      S_CHECK: begin
        entry_nxt_s = 16'h0000;
        if (entry_r == code_r) begin
          attempts_nxt_s = 2'd0;
          state_nxt_s    = S_OPEN;
        end else if (attempts_r == 2'd2) begin
          attempts_nxt_s = 2'd3;
          lock_cnt_nxt_s = '0;
          state_nxt_s    = S_LOCKOUT;
        end else begin
          attempts_nxt_s = (attempts_r == 2'd3) ? 2'd3 : attempts_r + 2'd1;
          state_nxt_s    = S_IDLE;
        end
      end
      S_OPEN: begin
        if (confirm || relock_expired_s) begin
          pos_nxt_s   = 2'd0;
          stage_nxt_s = 16'h0000;
          state_nxt_s = S_IDLE;
        end else if (!setup) begin
          pos_nxt_s   = 2'd0;
          stage_nxt_s = 16'h0000;
        end else if (digit_ok_s) begin
          if (pos_r == 2'd3) begin
            // New code commits only on the fourth digit.
            code_nxt_s  = set_digit(stage_r, 2'd3, digit);
            stage_nxt_s = 16'h0000;
            pos_nxt_s   = 2'd0;
          end else begin
            stage_nxt_s = set_digit(stage_r, pos_r, digit);
            pos_nxt_s   = pos_r + 2'd1;
          end
        end else begin
          state_nxt_s = S_OPEN;
        end
      end
      S_LOCKOUT: begin
        if (lock_cnt_r == LOCK_LAST) begin
          lock_cnt_nxt_s = '0;
          attempts_nxt_s = 2'd0;
          state_nxt_s    = S_IDLE;
        end else begin
          lock_cnt_nxt_s = lock_cnt_r + LOCK_W'(1);
        end
      end
      default: begin
        pos_nxt_s   = 2'd0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      pos_r        <= 2'd0;
      attempts_r   <= 2'd0;
      code_r       <= DEFAULT_CODE;
      entry_r      <= 16'h0000;
      stage_r      <= 16'h0000;
      lock_cnt_r   <= '0;
      unlocked_r   <= 1'b0;
      locked_out_r <= 1'b0;
      alarm_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pos_r        <= pos_nxt_s;
      attempts_r   <= attempts_nxt_s;
      code_r       <= code_nxt_s;
      entry_r      <= entry_nxt_s;
      stage_r      <= stage_nxt_s;
      lock_cnt_r   <= lock_cnt_nxt_s;
      unlocked_r   <= (state_nxt_s == S_OPEN);
      locked_out_r <= (state_nxt_s == S_LOCKOUT);
      alarm_r      <= (state_nxt_s == S_LOCKOUT) && (state_r != S_LOCKOUT);
    end
  end

  assign unlocked   = unlocked_r;
  assign locked_out = locked_out_r;
  assign alarm      = alarm_r;
  assign attempts   = attempts_r;
  assign pos        = pos_r;

endmodule
